// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared types and defaults for the unified-memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int c_def_aw         = 32;
    localparam int c_def_dw         = 32;
    localparam int c_def_mem_lat    = 1;
    localparam int c_def_starve_max = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic c_port0 = 1'b0;
    localparam logic c_port1 = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_sel.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_sel
// Description : Port-0-priority grant with a streak counter that yields to
//               port 1 after STARVE_MAX consecutive port-0 wins.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_sel
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = c_def_starve_max
) (
    input  logic clk,
    input  logic rst,
    input  logic m0_req,
    input  logic m1_req,
    input  logic arb_en,
    output logic gnt_valid,
    output logic gnt_port
);

    localparam int                    c_streak_w   = cnt_width(STARVE_MAX + 1);
    localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(STARVE_MAX);

    logic [c_streak_w-1:0] r_streak;

    always_comb begin
        gnt_valid = arb_en & (m0_req | m1_req);
        gnt_port  = c_port0;
        if (m1_req && (!m0_req || (r_streak == c_streak_max)))
            gnt_port = c_port1;
    end

    // Streak only counts port-0 wins that actually kept port 1 waiting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_streak <= '0;
        end else if (gnt_valid) begin
            if (gnt_port == c_port1 || !m1_req)
                r_streak <= '0;
            else if (r_streak != c_streak_max)
                r_streak <= r_streak + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-port sequencer for a fixed-latency unified memory; returns
//               a one-cycle ready pulse per access.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW         = c_def_aw,
    parameter int DW         = c_def_dw,
    parameter int MEM_LAT    = c_def_mem_lat,
    parameter int STARVE_MAX = c_def_starve_max
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ready,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ready,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner
);

    localparam int                 c_lat_w    = cnt_width(MEM_LAT);
    localparam logic [c_lat_w-1:0] c_lat_last = c_lat_w'(MEM_LAT - 1);

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [c_lat_w-1:0] r_lat_cnt;
    logic               r_we;
    logic               r_port;
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_wdata;
    logic [DW-1:0]      r_rdata0;
    logic [DW-1:0]      r_rdata1;
    logic               w_arb_en;
    logic               w_gnt_valid;
    logic               w_gnt_port;
    logic               w_lat_last;

    assign w_arb_en   = (r_state == ST_IDLE);
    assign w_lat_last = (r_state == ST_ACC) && (r_lat_cnt == c_lat_last);

    mem_arb_sel #(
        .STARVE_MAX (STARVE_MAX)
    ) u_sel (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m1_req    (m1_req),
        .arb_en    (w_arb_en),
        .gnt_valid (w_gnt_valid),
        .gnt_port  (w_gnt_port)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_gnt_valid) w_state_nxt = ST_ACC;
            ST_ACC:  if (w_lat_last)  w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Requests are latched at grant so requesters may churn their inputs mid-access.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_lat_cnt <= '0;
            r_we      <= 1'b0;
            r_port    <= c_port0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else if (w_arb_en && w_gnt_valid) begin
            r_lat_cnt <= '0;
            r_port    <= w_gnt_port;
            r_we      <= (w_gnt_port == c_port1) ? m1_we    : m0_we;
            r_addr    <= (w_gnt_port == c_port1) ? m1_addr  : m0_addr;
            r_wdata   <= (w_gnt_port == c_port1) ? m1_wdata : m0_wdata;
        end else if (r_state == ST_ACC) begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
            if (w_lat_last && !r_we) begin
                if (r_port == c_port1)
                    r_rdata1 <= mem_rdata;
                else
                    r_rdata0 <= mem_rdata;
            end
        end
    end

    assign mem_ce    = (r_state == ST_ACC);
    assign mem_we    = mem_ce && (r_lat_cnt == '0) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign owner     = r_port;
    assign m0_ready  = (r_state == ST_RESP) && (r_port == c_port0);
    assign m1_ready  = (r_state == ST_RESP) && (r_port == c_port1);
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed vector bench for mem_port_arbiter (MEM_LAT=1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        mem_ce, mem_we, owner;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        d3_m0_req, d3_m0_we, d3_m1_req, d3_m1_we;
    logic [31:0] d3_m0_addr, d3_m0_wdata, d3_m1_addr, d3_m1_wdata;
    logic [31:0] d3_m0_rdata, d3_m1_rdata;
    logic        d3_m0_ready, d3_m1_ready;
    logic        d3_mem_ce, d3_mem_we, d3_owner;
    logic [31:0] d3_mem_addr, d3_mem_wdata, d3_mem_rdata;

    logic [31:0] mem [0:63];
    logic [31:0] ce_cnt3;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst(rst),
        .m0_req(d3_m0_req), .m0_we(d3_m0_we), .m0_addr(d3_m0_addr), .m0_wdata(d3_m0_wdata),
        .m0_rdata(d3_m0_rdata), .m0_ready(d3_m0_ready),
        .m1_req(d3_m1_req), .m1_we(d3_m1_we), .m1_addr(d3_m1_addr), .m1_wdata(d3_m1_wdata),
        .m1_rdata(d3_m1_rdata), .m1_ready(d3_m1_ready),
        .mem_ce(d3_mem_ce), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr),
        .mem_wdata(d3_mem_wdata), .mem_rdata(d3_mem_rdata), .owner(d3_owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory for the MEM_LAT=1 instance; reset preloads 0x10 with DEADBEEF.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[4] <= 32'hDEAD_BEEF;
        end else if (mem_ce && mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    // MEM_LAT=3 memory returns A000_000k during the k-th enabled cycle.
    assign d3_mem_rdata = 32'hA000_0000 | (ce_cnt3 + 32'd1);
    always @(posedge clk) begin
        if (!rst || !d3_mem_ce) ce_cnt3 <= 32'd0;
        else                    ce_cnt3 <= ce_cnt3 + 32'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (p) begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end
    endtask

    function automatic logic rdy(input logic p);
        return p ? m1_ready : m0_ready;
    endfunction

    function automatic logic [31:0] rd(input logic p);
        return p ? m1_rdata : m0_rdata;
    endfunction

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        step();
        chk($sformatf("v%0d mem_ce", i), {31'd0, mem_ce}, 32'd1);
        chk($sformatf("v%0d mem_we", i), {31'd0, mem_we}, {31'd0, v.we});
        chk($sformatf("v%0d mem_addr", i), mem_addr, v.addr);
        if (v.we) chk($sformatf("v%0d mem_wdata", i), mem_wdata, v.wdata);
        chk($sformatf("v%0d owner", i), {31'd0, owner}, {31'd0, v.port});
        step();
        chk($sformatf("v%0d ready", i), {31'd0, rdy(v.port)}, 32'd1);
        chk($sformatf("v%0d other_ready", i), {31'd0, rdy(!v.port)}, 32'd0);
        chk($sformatf("v%0d ce_off", i), {30'd0, mem_ce, mem_we}, 32'd0);
        chk($sformatf("v%0d rdata", i), rd(v.port), v.exp_rdata);
        drive(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk($sformatf("v%0d ready_pulse", i), {31'd0, rdy(v.port)}, 32'd0);
    endtask

    initial begin
        int exp_order[10];
        int got;
        int cyc;
        int rdy_at;
        logic [5:0] ce_pat, we_pat, rdy_pat;
        logic [31:0] rdata_at;

        vecs[0] = '{port: 1'b0, we: 1'b0, addr: 32'h10, wdata: 32'h0,          exp_rdata: 32'hDEAD_BEEF};
        vecs[1] = '{port: 1'b1, we: 1'b1, addr: 32'h40, wdata: 32'h1234_5678,  exp_rdata: 32'h0};
        vecs[2] = '{port: 1'b1, we: 1'b0, addr: 32'h40, wdata: 32'h0,          exp_rdata: 32'h1234_5678};
        vecs[3] = '{port: 1'b0, we: 1'b1, addr: 32'h44, wdata: 32'hCAFE_F00D,  exp_rdata: 32'hDEAD_BEEF};
        vecs[4] = '{port: 1'b0, we: 1'b0, addr: 32'h44, wdata: 32'h0,          exp_rdata: 32'hCAFE_F00D};
        vecs[5] = '{port: 1'b1, we: 1'b0, addr: 32'h10, wdata: 32'h0,          exp_rdata: 32'hDEAD_BEEF};
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        d3_m0_req = 1'b0; d3_m0_we = 1'b0; d3_m0_addr = 32'h0; d3_m0_wdata = 32'h0;
        d3_m1_req = 1'b0; d3_m1_we = 1'b0; d3_m1_addr = 32'h0; d3_m1_wdata = 32'h0;
        repeat (3) step();

        chk("rst ctrl", {27'd0, mem_ce, mem_we, owner, m0_ready, m1_ready}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst mem_wdata", mem_wdata, 32'h0);
        chk("rst rdata", m0_rdata | m1_rdata, 32'h0);
        chk("rst d3 ctrl", {27'd0, d3_mem_ce, d3_mem_we, d3_owner, d3_m0_ready, d3_m1_ready}, 32'd0);
        chk("rst d3 rdata", d3_m0_rdata | d3_mem_addr, 32'h0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(i);

        // Both ports hold requests: port 1 wins once per STARVE_MAX port-0 grants.
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        got = 0;
        cyc = 0;
        while (got < 10 && cyc < 200) begin
            step();
            cyc++;
            if (m0_ready && m1_ready) begin
                chk("contention dual_ready", 32'd1, 32'd0);
                got++;
            end else if (m0_ready || m1_ready) begin
                chk($sformatf("contention grant%0d", got), {31'd0, m1_ready}, exp_order[got]);
                got++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("contention grants_seen", got, 32'd10);
        step();

        // Reset lands during a port-1 access.
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        step();
        chk("rstacc in_acc", {30'd0, mem_ce, owner}, 32'd3);
        rst = 1'b0;
        step();
        chk("rstacc ctrl", {27'd0, mem_ce, mem_we, owner, m0_ready, m1_ready}, 32'd0);
        chk("rstacc m1_rdata", m1_rdata, 32'h0);
        chk("rstacc mem_addr", mem_addr, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst = 1'b1;
        rdy_pat = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            rdy_pat[k] = m0_ready | m1_ready | mem_ce;
        end
        chk("rstacc quiet", {26'd0, rdy_pat}, 32'd0);
        run_vec(0);

        // MEM_LAT=3 read: enable for three cycles, ready on the fourth.
        d3_m0_req = 1'b1; d3_m0_we = 1'b0; d3_m0_addr = 32'h10;
        ce_pat = '0; we_pat = '0; rdy_pat = '0;
        rdy_at = -1;
        rdata_at = 32'h0;
        for (int k = 0; k < 6; k++) begin
            step();
            ce_pat[k]  = d3_mem_ce;
            we_pat[k]  = d3_mem_we;
            rdy_pat[k] = d3_m0_ready;
            if (d3_m0_ready && rdy_at < 0) begin
                rdy_at   = k + 1;
                rdata_at = d3_m0_rdata;
                d3_m0_req = 1'b0;
            end
        end
        d3_m0_req = 1'b0;
        chk("lat3 ce_pattern", {26'd0, ce_pat}, 32'b000111);
        chk("lat3 we_never", {26'd0, we_pat}, 32'd0);
        chk("lat3 ready_pattern", {26'd0, rdy_pat}, 32'b001000);
        chk("lat3 ready_cycle", rdy_at, 32'd4);
        chk("lat3 rdata", rdata_at, 32'hA000_0003);

        // Input churn during a MEM_LAT=3 write.
        d3_m0_req = 1'b1; d3_m0_we = 1'b1; d3_m0_addr = 32'h48; d3_m0_wdata = 32'h55AA_55AA;
        step();
        chk("churn acc1 we", {31'd0, d3_mem_we}, 32'd1);
        d3_m0_addr = 32'hFFFF_FFF0; d3_m0_wdata = 32'h0; d3_m0_we = 1'b0;
        for (int k = 2; k <= 3; k++) begin
            step();
            chk($sformatf("churn acc%0d addr", k), d3_mem_addr, 32'h48);
            chk($sformatf("churn acc%0d wdata", k), d3_mem_wdata, 32'h55AA_55AA);
            chk($sformatf("churn acc%0d ce_we", k), {30'd0, d3_mem_ce, d3_mem_we}, 32'd2);
        end
        step();
        chk("churn ready", {31'd0, d3_m0_ready}, 32'd1);
        chk("churn rdata_kept", d3_m0_rdata, 32'hA000_0003);
        d3_m0_req = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
